// File: rtl/cdb_arbiter.sv
// cdb_arbiter: terminates every execution pipe's result handshake in a small
// per-source FIFO and broadcasts up to CDB_COUNT FIFO heads per cycle on the
// common data bus. Sources are picked round-robin, and lanes are filled densely
// from lane 0.
module cdb_arbiter #(
    parameter int SRC_COUNT    = 4,
    parameter int FIFO_DEPTH   = 2,
    parameter int CDB_COUNT    = 2,
    parameter int DATA_WIDTH   = 32,
    parameter int ROB_ID_WIDTH = 6
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     flush,
    input  logic [SRC_COUNT-1:0]                     src_valid_i,
    input  logic [SRC_COUNT-1:0][DATA_WIDTH-1:0]     src_data_i,
    input  logic [SRC_COUNT-1:0][ROB_ID_WIDTH-1:0]   src_reg_id_i,
    output logic [SRC_COUNT-1:0]                     src_ready_o,
    output logic [CDB_COUNT-1:0][DATA_WIDTH-1:0]     cdb_data_o,
    output logic [CDB_COUNT-1:0][ROB_ID_WIDTH-1:0]   cdb_reg_id_o,
    output logic [CDB_COUNT-1:0]                     cdb_valid_o
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int SRC_W  = (SRC_COUNT > 1) ? $clog2(SRC_COUNT) : 1;
    localparam int LANE_W = (CDB_COUNT > 1) ? $clog2(CDB_COUNT) : 1;

    logic [DATA_WIDTH-1:0]   dataMem_q  [SRC_COUNT][FIFO_DEPTH];
    logic [ROB_ID_WIDTH-1:0] regIdMem_q [SRC_COUNT][FIFO_DEPTH];

    logic [PTR_W-1:0] wrPtr_q [SRC_COUNT];
    logic [PTR_W-1:0] wrPtr_d [SRC_COUNT];
    logic [PTR_W-1:0] rdPtr_q [SRC_COUNT];
    logic [PTR_W-1:0] rdPtr_d [SRC_COUNT];
    logic [CNT_W-1:0] count_q [SRC_COUNT];
    logic [CNT_W-1:0] count_d [SRC_COUNT];
    logic [SRC_W-1:0] rrPtr_q;
    logic [SRC_W-1:0] rrPtr_d;

    logic                 active;
    logic [SRC_COUNT-1:0] push;
    logic [SRC_COUNT-1:0] grant;
    logic [SRC_W-1:0]     lastGrant;
    logic [SRC_W-1:0]     scanIdx;
    logic [SRC_W:0]       scanSum;
    logic [LANE_W:0]      laneCnt;

    // Ready comes from the registered count only, so a same-cycle pop never
    // opens a full FIFO and there is no path from the CDB side to the sources.
    always_comb begin
        active = rst_n & ~flush;
        src_ready_o = '0;
        push = '0;
        for (int s = 0; s < SRC_COUNT; s++) begin
            src_ready_o[s] = (count_q[s] != CNT_W'(FIFO_DEPTH)) & active;
            push[s] = src_valid_i[s] & src_ready_o[s];
        end
    end

    // Cyclic scan from rrPtr_q. Each nonempty source takes the next free lane
    // until every lane is used. Nothing is granted during reset or flush.
    always_comb begin
        grant        = '0;
        laneCnt      = '0;
        lastGrant    = rrPtr_q;
        scanSum      = '0;
        scanIdx      = '0;
        cdb_valid_o  = '0;
        cdb_data_o   = '0;
        cdb_reg_id_o = '0;
        for (int k = 0; k < SRC_COUNT; k++) begin
            scanSum = {1'b0, rrPtr_q} + (SRC_W + 1)'(k);
            if (scanSum >= (SRC_W + 1)'(SRC_COUNT)) begin
                scanSum = scanSum - (SRC_W + 1)'(SRC_COUNT);
            end
            scanIdx = scanSum[SRC_W-1:0];
            if (active && (count_q[scanIdx] != '0) && (laneCnt < (LANE_W + 1)'(CDB_COUNT))) begin
                grant[scanIdx] = 1'b1;
                cdb_valid_o[laneCnt[LANE_W-1:0]]  = 1'b1;
                cdb_data_o[laneCnt[LANE_W-1:0]]   = dataMem_q[scanIdx][rdPtr_q[scanIdx]];
                cdb_reg_id_o[laneCnt[LANE_W-1:0]] = regIdMem_q[scanIdx][rdPtr_q[scanIdx]];
                laneCnt   = laneCnt + 1'b1;
                lastGrant = scanIdx;
            end
        end
    end

    // FIFO pointer and count updates. The round-robin pointer moves to just
    // past the last source granted this cycle, and holds if nothing was granted.
    always_comb begin
        for (int s = 0; s < SRC_COUNT; s++) begin
            wrPtr_d[s] = wrPtr_q[s] + PTR_W'(push[s]);
            rdPtr_d[s] = rdPtr_q[s] + PTR_W'(grant[s]);
            count_d[s] = count_q[s] + CNT_W'(push[s]) - CNT_W'(grant[s]);
        end
        rrPtr_d = rrPtr_q;
        if (|grant) begin
            if (lastGrant == SRC_W'(SRC_COUNT - 1)) begin
                rrPtr_d = '0;
            end else begin
                rrPtr_d = lastGrant + 1'b1;
            end
        end
    end

    // Control state register. Flush clears everything exactly as reset does.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            for (int s = 0; s < SRC_COUNT; s++) begin
                wrPtr_q[s] <= '0;
                rdPtr_q[s] <= '0;
                count_q[s] <= '0;
            end
            rrPtr_q <= '0;
        end else begin
            for (int s = 0; s < SRC_COUNT; s++) begin
                wrPtr_q[s] <= wrPtr_d[s];
                rdPtr_q[s] <= rdPtr_d[s];
                count_q[s] <= count_d[s];
            end
            rrPtr_q <= rrPtr_d;
        end
    end

    // FIFO storage has no reset. The push term already excludes reset and flush,
    // and stale entries are never read because the counts are cleared.
    always_ff @(posedge clk) begin
        for (int s = 0; s < SRC_COUNT; s++) begin
            if (push[s]) begin
                dataMem_q[s][wrPtr_q[s]]  <= src_data_i[s];
                regIdMem_q[s][wrPtr_q[s]] <= src_reg_id_i[s];
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: bench for cdb_arbiter. A scoreboard of per-source expected
// queues predicts every CDB lane and every ready bit. Table vectors and
// hand-written sequences add fixed expectations for the corner cases.
module tb_cdb_arbiter;

    localparam int SRC   = 4;
    localparam int DEPTH = 2;
    localparam int LANES = 2;
    localparam int DW    = 32;
    localparam int IW    = 6;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    logic [SRC-1:0]             src_valid_i;
    logic [SRC-1:0][DW-1:0]     src_data_i;
    logic [SRC-1:0][IW-1:0]     src_reg_id_i;
    logic [SRC-1:0]             src_ready_o;
    logic [LANES-1:0][DW-1:0]   cdb_data_o;
    logic [LANES-1:0][IW-1:0]   cdb_reg_id_o;
    logic [LANES-1:0]           cdb_valid_o;

    cdb_arbiter #(
        .SRC_COUNT(SRC), .FIFO_DEPTH(DEPTH), .CDB_COUNT(LANES),
        .DATA_WIDTH(DW), .ROB_ID_WIDTH(IW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .src_valid_i(src_valid_i), .src_data_i(src_data_i),
        .src_reg_id_i(src_reg_id_i), .src_ready_o(src_ready_o),
        .cdb_data_o(cdb_data_o), .cdb_reg_id_o(cdb_reg_id_o),
        .cdb_valid_o(cdb_valid_o)
    );

    // 10 ns clock with rising edges at 5, 15, 25 ns and so on
    always #5 clk = ~clk;

    typedef struct {
        logic [SRC-1:0]   valid;
        logic [LANES-1:0] expValid;
        logic [SRC-1:0]   expReady;
    } vec_t;

    vec_t vecs [6];

    logic [IW+DW-1:0]     sbQ [SRC][$];
    int                   mRr;
    int                   mLast;
    logic [SRC-1:0]       mGrant;
    logic [SRC-1:0]       mExpReady;
    logic                 mActive;
    int                   seq;
    int                   vectors;
    int                   miscompares;

    logic [LANES-1:0]         snapValid;
    logic [LANES-1:0][DW-1:0] snapData;
    logic [LANES-1:0][IW-1:0] snapId;
    logic [SRC-1:0]           snapReady;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [SRC-1:0] v, input logic fl);
        flush = fl;
        src_valid_i = v;
        for (int s = 0; s < SRC; s++) begin
            src_data_i[s]   = {8'(s), 24'(seq)};
            src_reg_id_i[s] = IW'(seq);
            seq++;
        end
    endtask

    // Predicts the lanes and ready bits from the scoreboard state and compares
    task automatic modelCheck();
        int s;
        int found;
        logic [IW+DW-1:0] head;
        mActive = rst_n && !flush;
        mGrant = '0;
        found = 0;
        for (int k = 0; k < SRC; k++) begin
            s = (mRr + k) % SRC;
            if (mActive && sbQ[s].size() != 0 && found < LANES) begin
                head = sbQ[s][0];
                mGrant[s] = 1'b1;
                checkOutput("lane.valid", 64'(cdb_valid_o[found]), 64'(1));
                checkOutput("lane.data", 64'(cdb_data_o[found]), 64'(head[DW-1:0]));
                checkOutput("lane.regId", 64'(cdb_reg_id_o[found]), 64'(head[IW+DW-1:DW]));
                mLast = s;
                found++;
            end
        end
        for (int l = found; l < LANES; l++) begin
            checkOutput("idleLane.valid", 64'(cdb_valid_o[l]), 64'(0));
            checkOutput("idleLane.data", 64'(cdb_data_o[l]), 64'(0));
            checkOutput("idleLane.regId", 64'(cdb_reg_id_o[l]), 64'(0));
        end
        for (int i = 0; i < SRC; i++) begin
            mExpReady[i] = mActive && (sbQ[i].size() != DEPTH);
        end
        checkOutput("srcReady", 64'(src_ready_o), 64'(mExpReady));
    endtask

    // Advances the scoreboard by one clock edge, using the inputs that the
    // DUT has just sampled
    task automatic modelUpdate();
        if (!mActive) begin
            for (int s = 0; s < SRC; s++) sbQ[s].delete();
            mRr = 0;
        end else begin
            for (int s = 0; s < SRC; s++) begin
                if (mGrant[s]) void'(sbQ[s].pop_front());
                if (src_valid_i[s] && mExpReady[s])
                    sbQ[s].push_back({src_reg_id_i[s], src_data_i[s]});
            end
            if (|mGrant) mRr = (mLast + 1) % SRC;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        snapValid = cdb_valid_o;
        snapData  = cdb_data_o;
        snapId    = cdb_reg_id_o;
        snapReady = src_ready_o;
        modelCheck();
        @(posedge clk);
        modelUpdate();
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus('0, 1'b0);
        tick();
        tick();
        checkOutput("reset.cdbValid", 64'(snapValid), 64'(0));
        checkOutput("reset.srcReady", 64'(snapReady), 64'(0));
        rst_n = 1'b1;
    endtask

    initial begin
        int gap;
        int maxGap;
        logic s3Seen;
        logic p;
        vectors = 0;
        miscompares = 0;
        seq = 0;
        mRr = 0;
        mLast = 0;
        mGrant = '0;
        mExpReady = '0;
        mActive = 1'b0;
        rst_n = 1'b0;
        applyStimulus('0, 1'b0);
        doReset();

        // Single result latency
        applyStimulus(4'b0100, 1'b0);
        src_data_i[2] = 32'hDEADBEEF;
        src_reg_id_i[2] = 6'd5;
        tick();
        checkOutput("single.firstReady", 64'(snapReady), 64'hF);
        checkOutput("single.sameCycle", 64'(snapValid), 64'(0));
        applyStimulus('0, 1'b0);
        tick();
        checkOutput("single.valid", 64'(snapValid), 64'b01);
        checkOutput("single.data", 64'(snapData[0]), 64'hDEADBEEF);
        checkOutput("single.regId", 64'(snapId[0]), 64'd5);
        tick();
        checkOutput("single.after", 64'(snapValid), 64'(0));

        // Full FIFO backpressure, checked against fixed vectors
        doReset();
        vecs[0] = '{valid: 4'b1111, expValid: 2'b00, expReady: 4'b1111};
        vecs[1] = '{valid: 4'b1111, expValid: 2'b11, expReady: 4'b1111};
        vecs[2] = '{valid: 4'b1111, expValid: 2'b11, expReady: 4'b0011};
        vecs[3] = '{valid: 4'b1111, expValid: 2'b11, expReady: 4'b1100};
        vecs[4] = '{valid: 4'b1111, expValid: 2'b11, expReady: 4'b0011};
        vecs[5] = '{valid: 4'b1111, expValid: 2'b11, expReady: 4'b1100};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].valid, 1'b0);
            tick();
            checkOutput("bp.valid", 64'(snapValid), 64'(vecs[i].expValid));
            checkOutput("bp.ready", 64'(snapReady), 64'(vecs[i].expReady));
        end
        applyStimulus('0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("bp.drained", 64'(snapValid), 64'(0));

        // Wrap-around on source 0
        doReset();
        for (int k = 1; k <= 6; k++) begin
            applyStimulus((k <= 5) ? 4'b0001 : 4'b0000, 1'b0);
            src_data_i[0] = 32'(k);
            tick();
            if (k >= 2) begin
                checkOutput("wrap.valid", 64'(snapValid), 64'b01);
                checkOutput("wrap.data", 64'(snapData[0]), 64'(k - 1));
            end
        end
        applyStimulus('0, 1'b0);
        tick();
        checkOutput("wrap.empty", 64'(snapValid), 64'(0));

        // Round-robin fairness: source 3 always valid, sources 0 and 1 pulsed
        doReset();
        gap = 0;
        maxGap = 0;
        for (int c = 0; c < 20; c++) begin
            p = (c % 2 == 0);
            applyStimulus({1'b1, 1'b0, p, p}, 1'b0);
            tick();
            if (c >= 1) begin
                s3Seen = 1'b0;
                for (int l = 0; l < LANES; l++)
                    if (snapValid[l] && snapData[l][31:24] == 8'd3) s3Seen = 1'b1;
                gap = s3Seen ? 0 : gap + 1;
                if (gap > maxGap) maxGap = gap;
            end
        end
        vectors++;
        if (maxGap > 1) begin
            miscompares++;
            $display("[TB] FAIL fair.gap: got %0d idle cycles in a row, expected at most 1", maxGap);
        end

        // Flush mid-operation
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b1111, 1'b0);
            tick();
        end
        applyStimulus(4'b0010, 1'b1);
        tick();
        checkOutput("flush.cycleValid", 64'(snapValid), 64'(0));
        checkOutput("flush.cycleReady", 64'(snapReady), 64'(0));
        applyStimulus('0, 1'b0);
        tick();
        checkOutput("flush.nextValid", 64'(snapValid), 64'(0));
        checkOutput("flush.nextReady", 64'(snapReady), 64'hF);
        tick();
        checkOutput("flush.dropped", 64'(snapValid), 64'(0));

        // Push and pop in the same cycle on source 0
        doReset();
        applyStimulus(4'b0001, 1'b0);
        src_data_i[0] = 32'hA1;
        tick();
        applyStimulus(4'b0001, 1'b0);
        src_data_i[0] = 32'hB2;
        tick();
        checkOutput("pp.valid", 64'(snapValid), 64'b01);
        checkOutput("pp.data", 64'(snapData[0]), 64'hA1);
        checkOutput("pp.ready", 64'(snapReady[0]), 64'(1));
        applyStimulus('0, 1'b0);
        tick();
        checkOutput("pp.secondValid", 64'(snapValid), 64'b01);
        checkOutput("pp.secondData", 64'(snapData[0]), 64'hB2);
        tick();
        checkOutput("pp.empty", 64'(snapValid), 64'(0));

        // Random traffic with occasional flushes
        doReset();
        for (int c = 0; c < 400; c++) begin
            applyStimulus(SRC'($urandom), ($urandom_range(0, 39) == 0));
            tick();
        end
        applyStimulus('0, 1'b0);
        for (int i = 0; i < 6; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
